keypad_scanner_4x4: RTL and testbench
=====================================

Name: keypad_scanner_4x4

Overview:
- Consumer of the 1 kHz tick from the 12 MHz tick divider.
- Drives the four active-low row lines of a 4x4 calculator keypad, one row per tick, and samples the four column lines.
- Debounces over whole scans and emits one key code plus a one-cycle valid pulse per stable press, and a release pulse per stable release.
- Feeds the calculator input decoder.

Parameters:
- DEBOUNCE_SCANS, 5, consecutive identical full scans required to accept a press (range 2..15).
- RELEASE_SCANS, 3, consecutive non-matching full scans required to accept a release (range 2..15).

Ports:
- clk_12MHz  input  1  system clock, 12 MHz.
- rst_n  input  1  reset, synchronous, active-low.
- scan_tick  input  1  single-cycle enable pulse, nominally 1 kHz.
- col_in  input  4  keypad columns, active-low, externally pulled up, asynchronous.
- row_out  output  4  keypad rows, active-low one-hot.
- key_code  output  4  accepted key = row*4 + col.
- key_valid  output  1  one-cycle pulse when a press is accepted.
- key_release  output  1  one-cycle pulse when a release is accepted.
- key_held  output  1  high while a key is accepted and not yet released.

Behaviour:
- One clock (clk_12MHz). Reset is synchronous and active-low (rst_n).
- Reset values:
  - row_out=4'b1110, row index=0, key_code=0.
  - key_valid=0, key_release=0, key_held=0.
  - state=SCAN, debounce count=0, scan accumulator cleared.
- rst_n low wins over any coincident scan_tick.
- col_in passes through a 2-flop synchronizer before use.
- Row drive and sampling, on each clk with scan_tick=1:
  - Sample the synchronized columns for the current row; the row has been driven for the full preceding tick period.
  - Advance the row index 0→1→2→3→0 and update row_out on the same edge.
  - A tick held high for N cycles counts as N ticks; callers must pulse it.
- Scan result: the tick that samples row 3 completes a full scan and raises an internal scan_done for one cycle. Per-scan result, accumulated across the 4 rows:
  - NONE: zero low column bits.
  - ONE(k): exactly one low bit overall, with k=row*4+col.
  - MULTI: two or more low bits. Treated as NONE for press purposes, so ghosting rejects the press.
- FSM, evaluated only on scan_done:
  - SCAN: ONE(k) → DEB_PRESS, cand=k, cnt=1. Otherwise stay.
  - DEB_PRESS:
    - ONE(cand): cnt+1. If cnt+1==DEBOUNCE_SCANS → HELD, key_code=cand, key_valid=1 for the next cycle.
    - ONE(j≠cand): cand=j, cnt=1.
    - NONE/MULTI → SCAN, cnt=0.
  - HELD: ONE(key_code) → stay. Anything else → DEB_RELEASE, cnt=1.
  - DEB_RELEASE:
    - ONE(key_code) → HELD. No new key_valid.
    - Otherwise cnt+1. If cnt+1==RELEASE_SCANS → SCAN, key_release=1 for the next cycle.
- Outputs:
  - key_held=1 in HELD and DEB_RELEASE; 0 otherwise.
  - key_code holds its value until the next accepted press.
- Latency: key_valid is asserted exactly 1 clk after the scan_tick that completes the DEBOUNCE_SCANS-th matching scan.
- A different key pressed while HELD is ignored until release has been accepted and a fresh full debounce completes.
- Reset during any state returns to SCAN. Partial debounce progress is discarded.

Decomposition:
- keypad_pkg holds:
  - state enum {SCAN, DEB_PRESS, HELD, DEB_RELEASE};
  - scan-result enum {RES_NONE, RES_ONE, RES_MULTI};
  - ROW_RESET=4'b1110;
  - KEY_W=4, CNT_W=4.
- One sub-module, keypad_col_sync: 4-bit 2-flop synchronizer on clk_12MHz, reset to 4'b1111.

Test Plan (bench may pulse scan_tick every 16 clks):
- Reset: rst_n low 3 clks → row_out=1110, key_code=0, key_valid=0, key_release=0, key_held=0; after 2 ticks row_out=1011.
- Clean press: hold col_in=1101 whenever row_out=1011 (key 9) for 5 full scans → one key_valid pulse 1 clk after the 20th tick, key_code=9, key_held=1.
- Bounce: key 9 for 3 scans, none for 1 scan, key 9 for 5 scans → exactly one key_valid, after the final 5th consecutive scan.
- Ghost reject: keys 0 and 5 pressed together for 10 scans → no key_valid, key_held stays 0.
- Release: after key 9 is accepted, release 1 scan then re-press → no key_release, no second key_valid. Then release 3 scans → one key_release pulse, key_held=0.
- Reset mid-debounce: rst_n low after 4 matching scans of key 3 → no key_valid. After release of rst_n, 5 further scans are required before key_valid with key_code=3.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package keypad_pkg;

  localparam int KEY_W = 4;
  localparam int CNT_W = 4;
  localparam logic [3:0] ROW_RESET = 4'b1110;

  typedef enum logic [1:0] {SCAN, DEB_PRESS, HELD, DEB_RELEASE} state_t;
  typedef enum logic [1:0] {RES_NONE, RES_ONE, RES_MULTI} scan_res_t;

  // Active-low one-hot row drive for a given row index.
  function automatic logic [3:0] row_drive(input logic [1:0] idx);
    row_drive = ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/keypad_col_sync.sv
// Two-flop synchronizer for the asynchronous, pulled-up keypad column lines.
module keypad_col_sync (
  input  logic       clk_12MHz,
  input  logic       rst_n,
  input  logic [3:0] col_in,
  output logic [3:0] col_sync
);

  logic [3:0] col_meta;

  always_ff @(posedge clk_12MHz) begin
    if (!rst_n) begin
      col_meta <= 4'b1111;
      col_sync <= 4'b1111;
    end else begin
      col_meta <= col_in;
      col_sync <= col_meta;
    end
  end

endmodule

// File: rtl/keypad_scanner_4x4.sv
// 4x4 keypad scanner: row drive, per-scan key accumulation, whole-scan debounce
// of presses and releases with ghost rejection.
module keypad_scanner_4x4
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 5,
  parameter int RELEASE_SCANS  = 3
) (
  input  logic             clk_12MHz,
  input  logic             rst_n,
  input  logic             scan_tick,
  input  logic [3:0]       col_in,
  output logic [3:0]       row_out,
  output logic [KEY_W-1:0] key_code,
  output logic             key_valid,
  output logic             key_release,
  output logic             key_held
);

  localparam logic [CNT_W-1:0] DEB_LIMIT = CNT_W'(DEBOUNCE_SCANS);
  localparam logic [CNT_W-1:0] REL_LIMIT = CNT_W'(RELEASE_SCANS);

  logic [3:0]       col_sync;
  logic [1:0]       row_idx;
  logic [1:0]       acc_cnt;
  logic [KEY_W-1:0] acc_key;

  logic [3:0]       row_lows;
  logic [2:0]       row_cnt;
  logic [1:0]       row_col;
  logic [1:0]       sum_cnt;
  logic [KEY_W-1:0] sum_key;
  logic             scan_done;
  scan_res_t        scan_res;

  state_t           state;
  logic [KEY_W-1:0] cand;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             match_held;

  keypad_col_sync u_col_sync (
    .clk_12MHz (clk_12MHz),
    .rst_n     (rst_n),
    .col_in    (col_in),
    .col_sync  (col_sync)
  );

  // Low-bit count saturates at 2, which is all that MULTI needs to know.
  always_comb begin
    row_lows = ~col_sync;
    row_cnt  = '0;
    row_col  = '0;
    for (int i = 0; i < 4; i++) begin
      row_cnt = row_cnt + {2'b00, row_lows[i]};
      if (row_lows[i]) row_col = 2'(i);
    end
    if (({1'b0, acc_cnt} + row_cnt) >= 3'd2) sum_cnt = 2'd2;
    else                                     sum_cnt = acc_cnt + row_cnt[1:0];
    sum_key   = (acc_cnt == 2'd0 && row_cnt == 3'd1) ? {row_idx, row_col} : acc_key;
    scan_done = scan_tick && (row_idx == 2'd3);
    case (sum_cnt)
      2'd0:    scan_res = RES_NONE;
      2'd1:    scan_res = RES_ONE;
      default: scan_res = RES_MULTI;
    endcase
    cnt_inc    = cnt + 1'b1;
    match_held = (scan_res == RES_ONE) && (sum_key == key_code);
  end

  always_ff @(posedge clk_12MHz) begin
    if (!rst_n) begin
      row_idx <= '0;
      row_out <= ROW_RESET;
      acc_cnt <= '0;
      acc_key <= '0;
    end else if (scan_tick) begin
      row_idx <= row_idx + 2'd1;
      row_out <= row_drive(row_idx + 2'd1);
      if (scan_done) begin
        acc_cnt <= '0;
        acc_key <= '0;
      end else begin
        acc_cnt <= sum_cnt;
        acc_key <= sum_key;
      end
    end
  end

  // Debounce FSM sees the completed scan on the same edge as the row-3 sample.
  always_ff @(posedge clk_12MHz) begin
    if (!rst_n) begin
      state       <= SCAN;
      cand        <= '0;
      cnt         <= '0;
      key_code    <= '0;
      key_valid   <= 1'b0;
      key_release <= 1'b0;
      key_held    <= 1'b0;
    end else begin
      key_valid   <= 1'b0;
      key_release <= 1'b0;
      if (scan_done) begin
        case (state)
          SCAN: begin
            if (scan_res == RES_ONE) begin
              state <= DEB_PRESS;
              cand  <= sum_key;
              cnt   <= CNT_W'(1);
            end
          end
          DEB_PRESS: begin
            if (scan_res == RES_ONE && sum_key == cand) begin
              cnt <= cnt_inc;
              if (cnt_inc == DEB_LIMIT) begin
                state     <= HELD;
                key_code  <= cand;
                key_valid <= 1'b1;
                key_held  <= 1'b1;
              end
            end else if (scan_res == RES_ONE) begin
              cand <= sum_key;
              cnt  <= CNT_W'(1);
            end else begin
              state <= SCAN;
              cnt   <= '0;
            end
          end
          HELD: begin
            if (!match_held) begin
              state <= DEB_RELEASE;
              cnt   <= CNT_W'(1);
            end
          end
          DEB_RELEASE: begin
            if (match_held) begin
              state <= HELD;
            end else begin
              cnt <= cnt_inc;
              if (cnt_inc == REL_LIMIT) begin
                state       <= SCAN;
                cnt         <= '0;
                key_release <= 1'b1;
                key_held    <= 1'b0;
              end
            end
          end
          default: state <= SCAN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner_4x4.sv
// Scoreboard bench for keypad_scanner_4x4: a keypad model answers the row drive,
// expected press/release events are queued with the tick on which they must appear.
module tb_keypad_scanner_4x4;

  typedef struct {
    int kind;
    int code;
    int tick;
  } exp_t;

  logic        clk_12MHz = 1'b0;
  logic        rst_n     = 1'b0;
  logic        scan_tick = 1'b0;
  logic [3:0]  col_in;
  logic [3:0]  row_out;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_release;
  logic        key_held;

  logic [15:0] pressed = '0;
  int          tick_seen = 0;
  logic        last_edge_tick = 1'b0;
  int          tests_run = 0;
  int          tests_failed = 0;
  exp_t        exp_q[$];
  exp_t        ev;

  keypad_scanner_4x4 dut (
    .clk_12MHz   (clk_12MHz),
    .rst_n       (rst_n),
    .scan_tick   (scan_tick),
    .col_in      (col_in),
    .row_out     (row_out),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .key_release (key_release),
    .key_held    (key_held)
  );

  always #5 clk_12MHz = ~clk_12MHz;

  // Pressed key at (r,c) pulls column c low while row r is driven low.
  always_comb begin
    col_in = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row_out[r] && pressed[r*4+c]) col_in[c] = 1'b0;
  end

  task automatic checkOutput(input string tag, input int actual, input int expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  always @(posedge clk_12MHz) begin
    if (scan_tick) tick_seen <= tick_seen + 1;
    last_edge_tick <= scan_tick;
  end

  always @(negedge clk_12MHz) begin
    if (rst_n && (key_valid || key_release)) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_event", 1, 0);
      end else begin
        ev = exp_q.pop_front();
        checkOutput("event_kind", int'(key_release), ev.kind);
        checkOutput("event_code", int'(key_code), ev.code);
        checkOutput("event_tick", tick_seen, ev.tick);
        checkOutput("event_latency", int'(last_edge_tick), 1);
      end
    end
  end

  task automatic one_tick();
    repeat (15) @(negedge clk_12MHz);
    scan_tick = 1'b1;
    @(negedge clk_12MHz);
    scan_tick = 1'b0;
  endtask

  task automatic applyStimulus(input logic [15:0] keys, input int scans);
    pressed = keys;
    repeat (scans * 4) one_tick();
    repeat (2) @(negedge clk_12MHz);
  endtask

  // kind 0 = press, 1 = release; due on the last tick of the given scan.
  task automatic expect_event(input int kind, input int code, input int scans_ahead);
    exp_t e;
    e.kind = kind;
    e.code = code;
    e.tick = tick_seen + 4 * scans_ahead;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk_12MHz);
  endtask

  initial begin
    do_reset();
    checkOutput("rst_row_out", int'(row_out), 4'b1110);
    checkOutput("rst_key_code", int'(key_code), 0);
    checkOutput("rst_key_valid", int'(key_valid), 0);
    checkOutput("rst_key_release", int'(key_release), 0);
    checkOutput("rst_key_held", int'(key_held), 0);
    rst_n = 1'b1;
    one_tick();
    @(negedge clk_12MHz);
    checkOutput("row_after_1_tick", int'(row_out), 4'b1101);
    one_tick();
    @(negedge clk_12MHz);
    checkOutput("row_after_2_ticks", int'(row_out), 4'b1011);
    one_tick();
    one_tick();
    @(negedge clk_12MHz);
    checkOutput("row_after_full_scan", int'(row_out), 4'b1110);

    // Clean press of key 9.
    expect_event(0, 9, 5);
    applyStimulus(16'h0200, 5);
    checkOutput("press9_held", int'(key_held), 1);
    checkOutput("press9_code", int'(key_code), 9);
    checkOutput("press9_q_empty", exp_q.size(), 0);

    // Short release then re-press: no events.
    applyStimulus(16'h0000, 1);
    applyStimulus(16'h0200, 1);
    checkOutput("repress_held", int'(key_held), 1);
    checkOutput("repress_q_empty", exp_q.size(), 0);
    expect_event(1, 9, 3);
    applyStimulus(16'h0000, 3);
    checkOutput("release9_held", int'(key_held), 0);
    checkOutput("release9_code", int'(key_code), 9);
    checkOutput("release9_q_empty", exp_q.size(), 0);

    // Bounce: 3 scans, gap, then a fresh 5-scan debounce.
    applyStimulus(16'h0200, 3);
    applyStimulus(16'h0000, 1);
    checkOutput("bounce_not_held", int'(key_held), 0);
    expect_event(0, 9, 5);
    applyStimulus(16'h0200, 5);
    checkOutput("bounce_held", int'(key_held), 1);
    checkOutput("bounce_q_empty", exp_q.size(), 0);
    expect_event(1, 9, 3);
    applyStimulus(16'h0000, 3);

    // Ghosting: keys 0 and 5 together never qualify.
    applyStimulus(16'h0021, 10);
    checkOutput("ghost_held", int'(key_held), 0);
    checkOutput("ghost_q_empty", exp_q.size(), 0);
    applyStimulus(16'h0000, 1);

    // Reset mid-debounce of key 3 discards progress.
    applyStimulus(16'h0008, 4);
    do_reset();
    checkOutput("midrst_row_out", int'(row_out), 4'b1110);
    checkOutput("midrst_code", int'(key_code), 0);
    checkOutput("midrst_held", int'(key_held), 0);
    rst_n = 1'b1;
    expect_event(0, 3, 5);
    applyStimulus(16'h0008, 5);
    checkOutput("key3_code", int'(key_code), 3);
    checkOutput("key3_held", int'(key_held), 1);
    checkOutput("key3_q_empty", exp_q.size(), 0);

    // Switching to key 6 while 3 is held: release first, then full debounce.
    expect_event(1, 3, 3);
    expect_event(0, 6, 8);
    applyStimulus(16'h0040, 8);
    checkOutput("key6_code", int'(key_code), 6);
    checkOutput("key6_held", int'(key_held), 1);
    checkOutput("key6_q_empty", exp_q.size(), 0);
    expect_event(1, 6, 3);
    applyStimulus(16'h0000, 3);
    checkOutput("final_held", int'(key_held), 0);
    checkOutput("final_q_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
